// File: rtl/match_ctrl_pkg.sv
// match_ctrl_pkg: shared definitions for the multi-channel match controller.
//   ch_state_e   per-channel scan state (IDLE=0, SCAN=1, HIT=2, END=3)
//   DEF_*        default widths and channel count used by the RTL parameters
package match_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HIT  = 2'd2,
        END  = 2'd3
    } ch_state_e;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_CNT_W  = 3;
    localparam int unsigned DEF_STAT_W = 8;

endpackage

// File: rtl/multi_match_controller_if.sv
// multi_match_controller_if: control/status bundle of the match controller.
//   start, abort, start_addr, etx, sp, match   -> controller (master drives)
//   ready, rd_en, address, char_count, done,
//   found, all_done, match_total               <- controller (slave drives)
// Optional feature: MATCH_STATS_EN adds match_total and its STAT_W parameter.
interface multi_match_controller_if
    import match_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
`ifdef MATCH_STATS_EN
    ,
    parameter int unsigned STAT_W = DEF_STAT_W
`endif
);

    logic                       start;
    logic                       abort;
    logic [NUM_CH*ADDR_W-1:0]   start_addr;
    logic [NUM_CH-1:0]          etx;
    logic [NUM_CH-1:0]          sp;
    logic [NUM_CH-1:0]          match;

    logic                       ready;
    logic [NUM_CH-1:0]          rd_en;
    logic [NUM_CH*ADDR_W-1:0]   address;
    logic [NUM_CH*CNT_W-1:0]    char_count;
    logic [NUM_CH-1:0]          done;
    logic [NUM_CH-1:0]          found;
    logic                       all_done;
`ifdef MATCH_STATS_EN
    logic [NUM_CH*STAT_W-1:0]   match_total;
`endif

    modport master (
        output start, abort, start_addr, etx, sp, match,
        input  ready, rd_en, address, char_count, done, found, all_done
`ifdef MATCH_STATS_EN
        ,
        input  match_total
`endif
    );

    modport slave (
        input  start, abort, start_addr, etx, sp, match,
        output ready, rd_en, address, char_count, done, found, all_done
`ifdef MATCH_STATS_EN
        ,
        output match_total
`endif
    );

endinterface

// File: rtl/match_ctrl_channel.sv
// match_ctrl_channel: one independent scan channel (IDLE/SCAN/HIT/END).
//   clock, reset        rising-edge clock, async active-low reset
//   start_acc, abort    accepted start (already gated by ready) and abort
//   start_addr          address loaded on entry to SCAN
//   etx, sp, match      this channel's end-of-text / space / match flags
//   rd_en               memory read enable, active low (0 only in SCAN)
//   address, char_count current address and characters since last space
//   done, found         finished (HIT or END) / finished on match
//   scanning            state is SCAN
//   finishing, staying  leaving SCAN via HIT/END this cycle / remaining in SCAN
//   match_total         SCAN->HIT count, saturating (MATCH_STATS_EN only)
module match_ctrl_channel
    import match_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
`ifdef MATCH_STATS_EN
    ,
    parameter int unsigned STAT_W = DEF_STAT_W
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_acc,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              etx,
    input  logic              sp,
    input  logic              match,
    output logic              rd_en,
    output logic [ADDR_W-1:0] address,
    output logic [CNT_W-1:0]  char_count,
    output logic              done,
    output logic              found,
    output logic              scanning,
    output logic              finishing,
    output logic              staying
`ifdef MATCH_STATS_EN
    ,
    output logic [STAT_W-1:0] match_total
`endif
);

    ch_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        finishing = 1'b0;
        staying   = 1'b0;
        unique case (state_q)
            SCAN: begin
                // abort wins, then match (even with etx), then etx
                if (abort) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d   = HIT;
                    finishing = 1'b1;
                end else if (etx) begin
                    state_d   = END;
                    finishing = 1'b1;
                end else begin
                    staying = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (sp) begin
                        cnt_d = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start_acc) begin
                    state_d = SCAN;
                    addr_d  = start_addr;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign scanning   = (state_q == SCAN);
    assign rd_en      = ~scanning;
    assign done       = (state_q == HIT) || (state_q == END);
    assign found      = (state_q == HIT);
    assign address    = addr_q;
    assign char_count = cnt_q;

`ifdef MATCH_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_q <= '0;
        end else if (state_q == SCAN && !abort && match && stat_q != '1) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign match_total = stat_q;
`endif

endmodule

// File: rtl/multi_match_controller.sv
// multi_match_controller: NUM_CH independent scan channels sharing start/abort.
//   clock, reset   rising-edge clock, async active-low reset
//   bus (slave)    start/abort/start_addr/etx/sp/match in;
//                  ready/rd_en/address/char_count/done/found/all_done out,
//                  plus match_total when MATCH_STATS_EN is defined
// ready is combinational (no channel in SCAN); all_done is a registered
// one-cycle pulse coinciding with the last channel's arrival in HIT/END.
module multi_match_controller
    import match_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned STAT_W = DEF_STAT_W
) (
    input logic                  clock,
    input logic                  reset,
    multi_match_controller_if.slave bus
);

    if (NUM_CH < 1 || NUM_CH > 8 || ADDR_W < 1 || CNT_W < 1 || STAT_W < 1) begin : g_param_check
        $error("multi_match_controller: parameter out of range");
    end

    logic [NUM_CH-1:0]        scanning;
    logic [NUM_CH-1:0]        finishing;
    logic [NUM_CH-1:0]        staying;
    logic [NUM_CH-1:0]        rd_en_v;
    logic [NUM_CH-1:0]        done_v;
    logic [NUM_CH-1:0]        found_v;
    logic [NUM_CH*ADDR_W-1:0] addr_v;
    logic [NUM_CH*CNT_W-1:0]  cnt_v;
`ifdef MATCH_STATS_EN
    logic [NUM_CH*STAT_W-1:0] stat_v;
`endif
    logic                     start_acc;
    logic                     all_done_q;

    assign bus.ready = ~|scanning;
    assign start_acc = bus.start & bus.ready & ~bus.abort;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        match_ctrl_channel #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
`ifdef MATCH_STATS_EN
            ,
            .STAT_W (STAT_W)
`endif
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .start_acc  (start_acc),
            .abort      (bus.abort),
            .start_addr (bus.start_addr[i*ADDR_W +: ADDR_W]),
            .etx        (bus.etx[i]),
            .sp         (bus.sp[i]),
            .match      (bus.match[i]),
            .rd_en      (rd_en_v[i]),
            .address    (addr_v[i*ADDR_W +: ADDR_W]),
            .char_count (cnt_v[i*CNT_W +: CNT_W]),
            .done       (done_v[i]),
            .found      (found_v[i]),
            .scanning   (scanning[i]),
            .finishing  (finishing[i]),
            .staying    (staying[i])
`ifdef MATCH_STATS_EN
            ,
            .match_total(stat_v[i*STAT_W +: STAT_W])
`endif
        );
    end

    // Pulse when at least one channel reaches HIT/END and none stays in SCAN.
    // finishing is already masked by abort, so an abort never produces a pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            all_done_q <= 1'b0;
        end else begin
            all_done_q <= (|finishing) & ~(|staying);
        end
    end

    assign bus.all_done   = all_done_q;
    assign bus.rd_en      = rd_en_v;
    assign bus.address    = addr_v;
    assign bus.char_count = cnt_v;
    assign bus.done       = done_v;
    assign bus.found      = found_v;
`ifdef MATCH_STATS_EN
    assign bus.match_total = stat_v;
`endif

endmodule

// File: tb/tb_multi_match_controller.sv
// tb_multi_match_controller: directed + randomized bench for multi_match_controller.
// Define MATCH_STATS_EN to also check match_total.
module tb_multi_match_controller;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STAT_W = 2;
    localparam int unsigned AMOD   = 1 << ADDR_W;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;
    localparam int unsigned SMAX   = (1 << STAT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    multi_match_controller_if #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
`ifdef MATCH_STATS_EN
        ,
        .STAT_W (STAT_W)
`endif
    ) bus ();

    multi_match_controller #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: per-channel flags and plain integers
    bit          m_busy  [NUM_CH];
    bit          m_done  [NUM_CH];
    bit          m_found [NUM_CH];
    int unsigned m_addr  [NUM_CH];
    int unsigned m_cnt   [NUM_CH];
    int unsigned m_stat  [NUM_CH];
    bit          m_all_done;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_found[i] = 0;
            m_addr[i] = 0; m_cnt[i] = 0; m_stat[i] = 0;
        end
        m_all_done = 0;
    endfunction

    function automatic void model_step();
        bit          rdy;
        bit          any_fin;
        bit          any_stay;
        int unsigned sa;
        rdy = 1; any_fin = 0; any_stay = 0;
        for (int i = 0; i < NUM_CH; i++) if (m_busy[i]) rdy = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sa = (int'(bus.start_addr >> (i * ADDR_W))) % AMOD;
            if (bus.abort) begin
                m_busy[i] = 0; m_done[i] = 0; m_found[i] = 0;
            end else if (m_busy[i]) begin
                if (bus.match[i]) begin
                    m_busy[i] = 0; m_done[i] = 1; m_found[i] = 1; any_fin = 1;
                    if (m_stat[i] < SMAX) m_stat[i]++;
                end else if (bus.etx[i]) begin
                    m_busy[i] = 0; m_done[i] = 1; m_found[i] = 0; any_fin = 1;
                end else begin
                    any_stay = 1;
                    m_addr[i] = (m_addr[i] + 1) % AMOD;
                    if (bus.sp[i]) m_cnt[i] = 0;
                    else if (m_cnt[i] < CMAX) m_cnt[i]++;
                end
            end else if (bus.start && rdy) begin
                m_busy[i] = 1; m_done[i] = 0; m_found[i] = 0;
                m_addr[i] = sa; m_cnt[i] = 0;
            end
        end
        m_all_done = any_fin && !any_stay;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] e_rd, e_addr, e_cnt, e_done, e_found, e_stat;
        logic        e_ready;
        e_rd = '0; e_addr = '0; e_cnt = '0; e_done = '0; e_found = '0; e_stat = '0;
        e_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_busy[i]) e_ready = 1'b0;
            e_rd[i]    = !m_busy[i];
            e_done[i]  = m_done[i];
            e_found[i] = m_found[i];
            e_addr = e_addr | (64'(m_addr[i]) << (i * ADDR_W));
            e_cnt  = e_cnt  | (64'(m_cnt[i])  << (i * CNT_W));
            e_stat = e_stat | (64'(m_stat[i]) << (i * STAT_W));
        end
        chk({tag, "/ready"},      64'(bus.ready),      64'(e_ready));
        chk({tag, "/rd_en"},      64'(bus.rd_en),      e_rd);
        chk({tag, "/address"},    64'(bus.address),    e_addr);
        chk({tag, "/char_count"}, 64'(bus.char_count), e_cnt);
        chk({tag, "/done"},       64'(bus.done),       e_done);
        chk({tag, "/found"},      64'(bus.found),      e_found);
        chk({tag, "/all_done"},   64'(bus.all_done),   64'(m_all_done));
`ifdef MATCH_STATS_EN
        chk({tag, "/match_total"}, 64'(bus.match_total), e_stat);
`else
        if (e_stat == 64'hFFFF_FFFF_FFFF_FFFF) $display("note: stat model saturated");
`endif
    endtask

    task automatic quiet_inputs();
        bus.start = 1'b0; bus.abort = 1'b0; bus.start_addr = '0;
        bus.etx = '0; bus.sp = '0; bus.match = '0;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

`ifdef MATCH_STATS_EN
    int unsigned exp_stat [5] = '{1, 2, 3, 3, 3};
`endif

    initial begin
        logic [31:0] r;

        quiet_inputs();
        model_reset();
        #2;
        check_model("reset");
        #10 reset = 1'b1;

        // Start both channels, scan 5 cycles with no etx/match
        bus.start_addr = {10'h040, 10'h100};
        bus.start = 1'b1;
        cycle("start");
        bus.start = 1'b0;
        repeat (5) cycle("scan5");
        chk("req040_address", 64'(bus.address), 64'({10'h045, 10'h105}));
        chk("req040_rd_en",   64'(bus.rd_en),   64'(2'b00));
        chk("req040_ready",   64'(bus.ready),   64'(1'b0));

        // start while scanning is ignored
        bus.start = 1'b1; bus.start_addr = {10'h3FF, 10'h3FF};
        cycle("start_ignored");
        quiet_inputs();
        chk("start_ignored_addr", 64'(bus.address), 64'({10'h046, 10'h106}));

        // ch0 match, then ch1 etx three cycles later
        bus.match = 2'b01;
        cycle("ch0_match");
        bus.match = 2'b00;
        chk("req041_done0",  64'(bus.done[0]),  64'(1'b1));
        chk("req041_found0", 64'(bus.found[0]), 64'(1'b1));
        chk("req041_no_all_done", 64'(bus.all_done), 64'(1'b0));
        repeat (2) cycle("ch1_scan");
        bus.etx = 2'b10;
        cycle("ch1_etx");
        bus.etx = 2'b00;
        chk("req041_done",     64'(bus.done),     64'(2'b11));
        chk("req041_found",    64'(bus.found),    64'(2'b01));
        chk("req041_all_done", 64'(bus.all_done), 64'(1'b1));
        chk("req041_rd_en",    64'(bus.rd_en),    64'(2'b11));
        cycle("post_all_done");
        chk("req041_pulse_end", 64'(bus.all_done), 64'(1'b0));

        // Address wrap on ch0
        bus.start_addr = {10'h000, 10'h3FE};
        bus.start = 1'b1;
        cycle("wrap_start");
        bus.start = 1'b0;
        chk("req022_clears_done", 64'(bus.done), 64'(2'b00));
        cycle("wrap1"); chk("req042_a1", 64'(bus.address[9:0]), 64'(10'h3FF));
        cycle("wrap2"); chk("req042_a2", 64'(bus.address[9:0]), 64'(10'h000));
        cycle("wrap3"); chk("req042_a3", 64'(bus.address[9:0]), 64'(10'h001));

        // abort together with start: everything to IDLE, no pulse
        bus.abort = 1'b1; bus.start = 1'b1;
        cycle("abort_start");
        quiet_inputs();
        chk("req044_ready",    64'(bus.ready),    64'(1'b1));
        chk("req044_all_done", 64'(bus.all_done), 64'(1'b0));
        chk("req044_rd_en",    64'(bus.rd_en),    64'(2'b11));
        cycle("after_abort");

        // char_count saturation then clear on sp
        bus.start = 1'b1; bus.start_addr = {10'h123, 10'h321};
        cycle("cnt_start");
        bus.start = 1'b0;
        repeat (10) cycle("cnt_run");
        chk("req043_sat", 64'(bus.char_count[CNT_W-1:0]), 64'(CMAX));
        bus.sp = 2'b11;
        cycle("cnt_sp");
        bus.sp = 2'b00;
        chk("req043_clear", 64'(bus.char_count[CNT_W-1:0]), 64'(0));

        // simultaneous finish; ch0 sees match and etx together
        bus.match = 2'b01; bus.etx = 2'b11;
        cycle("both_finish");
        quiet_inputs();
        chk("req026_found",    64'(bus.found),    64'(2'b01));
        chk("req033_together", 64'(bus.all_done), 64'(1'b1));
        cycle("both_finish_after");

        // reset asserted mid-scan takes effect without a clock edge
        bus.start = 1'b1; bus.start_addr = {10'h2AA, 10'h155};
        cycle("rst_start");
        bus.start = 1'b0;
        repeat (3) cycle("rst_scan");
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        #2 reset = 1'b1;
        cycle("after_reset");
        chk("req035_no_pulse", 64'(bus.all_done), 64'(1'b0));

        // five searches each ending on match
        for (int k = 0; k < 5; k++) begin
            r = $urandom();
            bus.start_addr = r[NUM_CH*ADDR_W-1:0];
            bus.start = 1'b1;
            cycle("stat_start");
            bus.start = 1'b0;
            bus.match = 2'b11;
            cycle("stat_hit");
            bus.match = 2'b00;
`ifdef MATCH_STATS_EN
            chk("req045_stat0", 64'(bus.match_total[STAT_W-1:0]), 64'(exp_stat[k]));
`endif
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            bus.start_addr = r[NUM_CH*ADDR_W-1:0];
            bus.start = ($urandom_range(0, 3) == 0);
            bus.abort = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                bus.etx[i]   = ($urandom_range(0, 9) == 0);
                bus.match[i] = ($urandom_range(0, 11) == 0);
                bus.sp[i]    = ($urandom_range(0, 4) == 0);
            end
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
